// File: rtl/stopwatch_if.sv
// stopwatch_if: buttons and chain feedback in; counter-chain and display controls out.
// master = button/chain side, slave = stopwatch_ctrl.
interface stopwatch_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       chain_ovf;
  logic       tick_en;
  logic       chain_clr;
  logic       latch_en;
  logic       running;
  logic [1:0] state;
  logic       ovf_flag;

  modport master (
    output btn_ss, btn_lap, btn_clr, chain_ovf,
    input  tick_en, chain_clr, latch_en,
    input  running, state, ovf_flag
  );

  modport slave (
    input  btn_ss, btn_lap, btn_clr, chain_ovf,
    output tick_en, chain_clr, latch_en,
    output running, state, ovf_flag
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-edge FSM, tick prescaler and display latch control.
// Lap-time freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 250000,
  parameter int DIV_W    = 18
) (
  input  logic       clk,
  input  logic       reset,
  stopwatch_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           st_q, st_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clr_q, clr_d;
  logic             ovf_q, ovf_d;
  logic             ss_q, cb_q;
  logic             ss_ev, lap_ev, clr_ev;
  logic             run_w, tick_w;

  assign ss_ev  = sw.btn_ss & ~ss_q;
  assign clr_ev = sw.btn_clr & ~cb_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_q;

  always_ff @(posedge clk) begin
    if (reset) lap_q <= 1'b1;
    else       lap_q <= sw.btn_lap;
  end

  assign lap_ev      = sw.btn_lap & ~lap_q;
  assign sw.latch_en = (st_q != LAP);
  assign sw.state    = st_q;
`else
  assign lap_ev      = 1'b0;
  assign sw.latch_en = 1'b1;
  assign sw.state    = (st_q == LAP) ? RUN : st_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      div_q <= '0;
      clr_q <= 1'b0;
      ovf_q <= 1'b0;
      ss_q  <= 1'b1;
      cb_q  <= 1'b1;
    end else begin
      st_q  <= st_d;
      div_q <= div_d;
      clr_q <= clr_d;
      ovf_q <= ovf_d;
      ss_q  <= sw.btn_ss;
      cb_q  <= sw.btn_clr;
    end
  end

  assign run_w  = (st_q == RUN) || (st_q == LAP);
  assign tick_w = run_w && (div_q == DIV_MAX);

  always_comb begin
    st_d  = st_q;
    div_d = div_q;
    clr_d = 1'b0;
    ovf_d = ovf_q;
    if (run_w) div_d = tick_w ? '0 : div_q + DIV_ONE;
    unique case (st_q)
      IDLE: begin
        if (ss_ev) st_d = RUN;
        else if (clr_ev && !lap_ev) clr_d = 1'b1;
      end
      PAUSE: begin
        if (ss_ev) begin
          st_d = RUN;
        end else if (clr_ev && !lap_ev) begin
          st_d  = IDLE;
          clr_d = 1'b1;
          ovf_d = 1'b0;
          div_d = '0;
        end
      end
      // RUN and LAP share everything except the lap toggle target
      default: begin
        if (sw.chain_ovf) begin
          st_d  = PAUSE;
          ovf_d = 1'b1;
        end else if (ss_ev) begin
          st_d = PAUSE;
        end else if (lap_ev) begin
          st_d = (st_q == LAP) ? RUN : LAP;
        end
      end
    endcase
  end

  assign sw.tick_en   = tick_w;
  assign sw.chain_clr = clr_q;
  assign sw.running   = run_w;
  assign sw.ovf_flag  = ovf_q;

endmodule
